// File: rtl/cdb_pkg.sv
// cdb_pkg: shared constants and types for the common data bus arbiter.
//   TAG_W, DATA_W : default tag and value widths of a broadcast
//   NUM_UNITS     : number of functional-unit result ports
//   UNIT_*        : requester index of each functional unit
//   unit_idx_t    : requester index / priority pointer type
package cdb_pkg;

    localparam int TAG_W     = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_UNITS = 5;

    typedef logic [2:0] unit_idx_t;

    localparam unit_idx_t UNIT_ADD   = 3'd0;
    localparam unit_idx_t UNIT_LOGIC = 3'd1;
    localparam unit_idx_t UNIT_MUL   = 3'd2;
    localparam unit_idx_t UNIT_LOAD  = 3'd3;
    localparam unit_idx_t UNIT_STORE = 3'd4;

    // Index following idx in round-robin order, wrapping the last unit to 0.
    function automatic unit_idx_t next_unit(input unit_idx_t idx);
        return (idx == unit_idx_t'(NUM_UNITS - 1)) ? unit_idx_t'(0) : idx + unit_idx_t'(1);
    endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// rr_pick: combinational 5-input round-robin selector.
//   req       : request vector, bit i = requester i
//   ptr       : highest-priority index (0..NUM_UNITS-1)
//   grant     : one-hot grant of the first requester at or after ptr (or zero)
//   winner    : index of the granted requester (0 when none)
//   any_grant : at least one request was granted
module rr_pick
    import cdb_pkg::*;
(
    input  logic [NUM_UNITS-1:0] req,
    input  unit_idx_t            ptr,
    output logic [NUM_UNITS-1:0] grant,
    output unit_idx_t            winner,
    output logic                 any_grant
);

    logic [3:0] pos;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        pos       = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            // Walk ptr, ptr+1, ... modulo NUM_UNITS; first hit wins.
            pos = {1'b0, ptr} + 4'(i);
            if (pos >= 4'(NUM_UNITS)) begin
                pos = pos - 4'(NUM_UNITS);
            end
            if (!any_grant && req[pos[2:0]]) begin
                grant[pos[2:0]] = 1'b1;
                winner          = pos[2:0];
                any_grant       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and output register for the common data bus.
//   clk, rst                  : clock, asynchronous active-high reset
//   in_stall                  : downstream busy, suppresses all grants
//   in_request_/in_tag_/in_val_{add,logic,mul,load,store} : unit results
//   out_grant_{...}           : combinational grant, transfer on request && grant
//   out_broadcast             : registered one-cycle pulse per transfer
//   out_tag, out_val          : registered tag/value of the last transfer
module cdb_arbiter #(
    parameter int TAG_W  = cdb_pkg::TAG_W,
    parameter int DATA_W = cdb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_stall,
    input  logic              in_request_add,
    input  logic              in_request_logic,
    input  logic              in_request_mul,
    input  logic              in_request_load,
    input  logic              in_request_store,
    input  logic [TAG_W-1:0]  in_tag_add,
    input  logic [TAG_W-1:0]  in_tag_logic,
    input  logic [TAG_W-1:0]  in_tag_mul,
    input  logic [TAG_W-1:0]  in_tag_load,
    input  logic [TAG_W-1:0]  in_tag_store,
    input  logic [DATA_W-1:0] in_val_add,
    input  logic [DATA_W-1:0] in_val_logic,
    input  logic [DATA_W-1:0] in_val_mul,
    input  logic [DATA_W-1:0] in_val_load,
    input  logic [DATA_W-1:0] in_val_store,
    output logic              out_grant_add,
    output logic              out_grant_logic,
    output logic              out_grant_mul,
    output logic              out_grant_load,
    output logic              out_grant_store,
    output logic              out_broadcast,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_val
);

    import cdb_pkg::*;

    logic [NUM_UNITS-1:0] req_p0;
    logic [NUM_UNITS-1:0] grant_p0;
    unit_idx_t            winner_p0;
    logic                 vld_p0;
    logic [TAG_W-1:0]     tag_arr_p0 [NUM_UNITS];
    logic [DATA_W-1:0]    val_arr_p0 [NUM_UNITS];

    unit_idx_t            ptr_p1;
    logic                 vld_p1;
    logic [TAG_W-1:0]     tag_p1;
    logic [DATA_W-1:0]    val_p1;

    // Stage 0: bundle unit ports, gate with stall/reset, round-robin select.
    // Gating with rst keeps grants low during reset so no requester
    // believes its result was consumed by a void transfer.
    assign req_p0 = {in_request_store, in_request_load, in_request_mul,
                     in_request_logic, in_request_add} & {NUM_UNITS{!in_stall && !rst}};

    assign tag_arr_p0[UNIT_ADD]   = in_tag_add;
    assign tag_arr_p0[UNIT_LOGIC] = in_tag_logic;
    assign tag_arr_p0[UNIT_MUL]   = in_tag_mul;
    assign tag_arr_p0[UNIT_LOAD]  = in_tag_load;
    assign tag_arr_p0[UNIT_STORE] = in_tag_store;

    assign val_arr_p0[UNIT_ADD]   = in_val_add;
    assign val_arr_p0[UNIT_LOGIC] = in_val_logic;
    assign val_arr_p0[UNIT_MUL]   = in_val_mul;
    assign val_arr_p0[UNIT_LOAD]  = in_val_load;
    assign val_arr_p0[UNIT_STORE] = in_val_store;

    rr_pick u_rr_pick (
        .req       (req_p0),
        .ptr       (ptr_p1),
        .grant     (grant_p0),
        .winner    (winner_p0),
        .any_grant (vld_p0)
    );

    assign out_grant_add   = grant_p0[UNIT_ADD];
    assign out_grant_logic = grant_p0[UNIT_LOGIC];
    assign out_grant_mul   = grant_p0[UNIT_MUL];
    assign out_grant_load  = grant_p0[UNIT_LOAD];
    assign out_grant_store = grant_p0[UNIT_STORE];

    // Stage 1: broadcast register and priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_p1 <= '0;
            vld_p1 <= 1'b0;
            tag_p1 <= '0;
            val_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                ptr_p1 <= next_unit(winner_p0);
                tag_p1 <= tag_arr_p0[winner_p0];
                val_p1 <= val_arr_p0[winner_p0];
            end
        end
    end

    assign out_broadcast = vld_p1;
    assign out_tag       = tag_p1;
    assign out_val       = val_p1;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter and output register for the common data bus (CDB). Five functional-unit result ports (add, logic, mul, load, store) each present a request with tag and value. The block grants exactly one requester per cycle and broadcasts the winner's tag/value, registered, to the reservation stations and register file. It replaces fixed-priority selection with starvation-free rotation and adds a stall input from downstream.

## Interface
- TAG_W, 5, width of the reservation-station tag
- DATA_W, 32, width of the broadcast value
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high; clears all state immediately
- in_stall  in  1  downstream cannot accept a broadcast; no grant this cycle
- in_request_{add,logic,mul,load,store}  in  1  result valid, level-held until granted
- in_tag_{add,logic,mul,load,store}  in  TAG_W  result tag
- in_val_{add,logic,mul,load,store}  in  DATA_W  result value
- out_grant_{add,logic,mul,load,store}  out  1  combinational grant; transfer occurs at posedge when request && grant
- out_broadcast  out  1  registered; one-cycle pulse per transferred result
- out_tag  out  TAG_W  registered tag of last transfer
- out_val  out  DATA_W  registered value of last transfer

## Operation
- Requester index order: add=0, logic=1, mul=2, load=3, store=4.
- Priority pointer ptr (3 bits, values 0..4) names the highest-priority requester; search order is ptr, ptr+1, … wrapping 4->0.
- Grant: if in_stall=0 and any request is high, the first requesting index in search order gets grant=1; all others 0. At most one grant high (one-hot or zero).
- No request, or in_stall=1: all grants 0.
- On posedge with a grant: out_broadcast<=1, out_tag/out_val<=winner's inputs, ptr<=(winner+1) mod 5.
- On posedge without grant: out_broadcast<=0; out_tag, out_val, ptr hold.
- A requester seeing request&&grant at an edge treats its result as consumed; it deasserts request or presents its next result before the following edge. The arbiter does not mask or remember past grants.
- Request high with changing tag/value while not granted is legal; the value sampled at the granting edge is broadcast.
- Grant may depend combinationally on request and in_stall; no combinational path from request to out_broadcast/out_tag/out_val.

## Timing
- Reset values: out_broadcast=0, out_tag=0, out_val=0, ptr=0 (add highest). Grants are 0 while rst=1.
- Latency: request sampled at edge N appears on out_* after edge N (visible during cycle N+1).
- Throughput: one broadcast per cycle; back-to-back pulses when requests persist.
- Fairness: a continuously requesting unit is granted within 5 cycles of unstalled operation.
- in_stall asserted in the same cycle as requests: no transfer, ptr unchanged, out_broadcast=0 next cycle.
- rst asserted mid-operation: outputs and ptr clear asynchronously; any in-flight grant is void (no transfer).
- All five requesting simultaneously from ptr=0: grant order add, logic, mul, load, store, repeat.

## Structure
- Shared package cdb_pkg: TAG_W, DATA_W, NUM_UNITS=5, unit index constants (UNIT_ADD..UNIT_STORE), unit-index type.
- Sub-module rr_pick: 5-input round-robin selector (request vector, ptr -> one-hot grant, winner index, any_grant); purely combinational, reusable for reservation-station issue selection.
- Top level: input bundling into vectors, rr_pick instance, output/ptr registers.

## Test plan
- Reset: assert rst mid-broadcast -> out_broadcast=0, out_tag=0, out_val=0 immediately; grants 0.
- Single requester: after reset, logic requests tag 3 val 7 -> out_grant_logic=1 that cycle; next cycle out_broadcast=1, tag 3, val 7; ptr=2.
- Contention with rotation: from ptr=2, add (tag 5, val 1) and load (tag 9, val 15) request together -> load broadcast first, then add on the next cycle; ptr ends at 1.
- Full load: all five hold requests from ptr=0 for 10 cycles -> broadcast order add, logic, mul, load, store twice; out_broadcast high every cycle.
- Stall: two requests pending, in_stall=1 for 3 cycles -> no grants, out_broadcast=0, out_tag/out_val hold; on release, grant follows pointer as before stall.
- Idle hold: after a broadcast of tag 9 val 15, no requests -> out_broadcast drops to 0 next cycle, out_tag=9, out_val=15 retained.
